// File: rtl/boson_video_pkg.sv
// Shared types and default geometry for the Boson parallel video receiver.
package boson_video_pkg;

    typedef enum logic [1:0] {
        S_DISABLED = 2'd0,
        S_SEEK     = 2'd1,
        S_ACTIVE   = 2'd2,
        S_DROP     = 2'd3
    } state_t;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_V_ACTIVE = 512;

    // One FIFO entry: two packed pixels plus frame/line markers (34 bits).
    typedef struct packed {
        logic        sof;
        logic        eol;
        logic [31:0] data;
    } word_t;

endpackage

// File: rtl/boson_rx_fifo.sv
// First-word-fall-through FIFO carrying packed pixel words with sof/eol markers.
module boson_rx_fifo
    import boson_video_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     wr_en,
    input  logic [$bits(word_t)-1:0] wr_data,
    input  logic                     rd_en,
    output logic [$bits(word_t)-1:0] rd_data,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [$bits(word_t)-1:0] mem [DEPTH];
    logic [AW:0]              wr_ptr;
    logic [AW:0]              rd_ptr;
    logic                     push;
    logic                     pop;

    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign pop  = rd_en && !empty;
    assign push = wr_en && (!full || pop);

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/boson_video_rx.sv
// Boson CMOS video capture: input register, pixel-pair packer, frame FSM,
// geometry/overflow error flags and an output FWFT FIFO.
module boson_video_rx
    import boson_video_pkg::*;
#(
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cam_vsync,
    input  logic        cam_hsync,
    input  logic        cam_valid,
    input  logic [15:0] cam_data,
    input  logic        cap_en,
    input  logic        err_clr,
    output logic [31:0] out_data,
    output logic        out_sof,
    output logic        out_eol,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        frame_done,
    output logic [15:0] frame_count,
    output logic        err_ovf,
    output logic        err_line,
    output logic        err_frame
);

    localparam logic [15:0] X_LINE = 16'(H_ACTIVE);
    localparam logic [15:0] Y_LAST = 16'(V_ACTIVE - 1);

    logic        r_vsync, r_hsync, r_valid;
    logic [15:0] r_data;
    logic        vsync_d, valid_d;
    logic        vsync_rise, line_end;
    logic        unused_hsync;

    state_t      state;
    logic [15:0] x_cnt, y_cnt;
    logic [15:0] hold;
    logic        sof_armed;
    logic        wr_en;
    word_t       wr_word;

    word_t       push_word, head_word;
    logic        fifo_full, fifo_empty;
    logic        rd, accept, ovf, push, eol_now;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_vsync <= 1'b0;
            r_hsync <= 1'b0;
            r_valid <= 1'b0;
            r_data  <= '0;
            vsync_d <= 1'b0;
            valid_d <= 1'b0;
        end else begin
            r_vsync <= cam_vsync;
            r_hsync <= cam_hsync;
            r_valid <= cam_valid;
            r_data  <= cam_data;
            vsync_d <= r_vsync;
            valid_d <= r_valid;
        end
    end

    // hsync is captured with the other camera pins but line timing comes from valid.
    assign unused_hsync = r_hsync;

    assign vsync_rise = r_vsync && !vsync_d;
    assign line_end   = valid_d && !r_valid;

    assign rd     = out_valid && out_ready;
    assign accept = !fifo_full || rd;
    assign ovf    = wr_en && !accept;
    assign push   = wr_en && accept && (state != S_DROP);

    // An even-length line's last word is already in the write stage when its end is seen.
    assign eol_now = (state == S_ACTIVE) && line_end && !vsync_rise
                   && !x_cnt[0] && (x_cnt != 16'd0);

    always_comb begin
        push_word     = wr_word;
        push_word.eol = wr_word.eol || eol_now;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= S_DISABLED;
            x_cnt       <= '0;
            y_cnt       <= '0;
            hold        <= '0;
            sof_armed   <= 1'b0;
            wr_en       <= 1'b0;
            wr_word     <= '0;
            frame_done  <= 1'b0;
            frame_count <= '0;
            err_ovf     <= 1'b0;
            err_line    <= 1'b0;
            err_frame   <= 1'b0;
        end else begin
            wr_en      <= 1'b0;
            frame_done <= 1'b0;

            // NOTE: the clear comes first so any set below in the same cycle wins.
            if (err_clr) begin
                err_ovf   <= 1'b0;
                err_line  <= 1'b0;
                err_frame <= 1'b0;
            end

            case (state)
                S_DISABLED: begin
                    if (cap_en) state <= S_SEEK;
                end

                S_SEEK, S_DROP: begin
                    if (!cap_en) begin
                        state <= S_DISABLED;
                    end else if (vsync_rise) begin
                        x_cnt     <= '0;
                        y_cnt     <= '0;
                        sof_armed <= 1'b1;
                        state     <= S_ACTIVE;
                    end
                end

                S_ACTIVE: begin
                    if (vsync_rise) begin
                        err_frame <= 1'b1;
                        x_cnt     <= '0;
                        y_cnt     <= '0;
                        sof_armed <= 1'b1;
                    end else if (r_valid) begin
                        x_cnt <= x_cnt + 16'd1;
                        if (!x_cnt[0]) begin
                            hold <= r_data;
                        end else begin
                            wr_en        <= 1'b1;
                            wr_word.sof  <= sof_armed;
                            wr_word.eol  <= 1'b0;
                            wr_word.data <= {r_data, hold};
                            sof_armed    <= 1'b0;
                        end
                    end else if (line_end && (x_cnt != 16'd0)) begin
                        if (x_cnt[0]) begin
                            wr_en        <= 1'b1;
                            wr_word.sof  <= sof_armed;
                            wr_word.eol  <= 1'b1;
                            wr_word.data <= {16'h0000, hold};
                            sof_armed    <= 1'b0;
                        end
                        if (x_cnt != X_LINE) err_line <= 1'b1;
                        x_cnt <= '0;
                        if (y_cnt == Y_LAST) begin
                            y_cnt       <= '0;
                            frame_done  <= 1'b1;
                            frame_count <= frame_count + 16'd1;
                            state       <= cap_en ? S_SEEK : S_DISABLED;
                        end else begin
                            y_cnt <= y_cnt + 16'd1;
                        end
                    end
                end

                default: state <= S_DISABLED;
            endcase

            // Overflow overrides any transition above; the rest of the frame is dropped.
            if (ovf && (state != S_DROP)) begin
                err_ovf <= 1'b1;
                state   <= S_DROP;
            end
        end
    end

    boson_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .wr_en   (push),
        .wr_data (push_word),
        .rd_en   (rd),
        .rd_data (head_word),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign out_valid = !fifo_empty;
    assign out_data  = out_valid ? head_word.data : 32'd0;
    assign out_sof   = out_valid && head_word.sof;
    assign out_eol   = out_valid && head_word.eol;

endmodule

// File: tb/tb_boson_video_rx.sv
// Scoreboard bench for boson_video_rx with a 4x2 frame and a 2-word FIFO.
module tb_boson_video_rx;
    import boson_video_pkg::*;

    localparam int H = 4;
    localparam int V = 2;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        resetn;
    logic        cam_vsync, cam_hsync, cam_valid;
    logic [15:0] cam_data;
    logic        cap_en, err_clr;
    logic [31:0] out_data;
    logic        out_sof, out_eol, out_valid, out_ready;
    logic        frame_done;
    logic [15:0] frame_count;
    logic        err_ovf, err_line, err_frame;

    word_t exp_q[$];
    int    n_checks = 0;
    int    n_fail = 0;
    int    done_total = 0;
    bit    seen_valid = 1'b0;

    always #5 clk = ~clk;

    boson_video_rx #(
        .H_ACTIVE   (H),
        .V_ACTIVE   (V),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .cam_vsync   (cam_vsync),
        .cam_hsync   (cam_hsync),
        .cam_valid   (cam_valid),
        .cam_data    (cam_data),
        .cap_en      (cap_en),
        .err_clr     (err_clr),
        .out_data    (out_data),
        .out_sof     (out_sof),
        .out_eol     (out_eol),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .frame_done  (frame_done),
        .frame_count (frame_count),
        .err_ovf     (err_ovf),
        .err_line    (err_line),
        .err_frame   (err_frame)
    );

    // One clock: observe outputs at the falling edge, then return just after the rising edge.
    task automatic cycle();
        word_t e;
        @(negedge clk);
        if (frame_done) done_total++;
        if (out_valid) seen_valid = 1'b1;
        if (out_valid && out_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL word_unexpected: got data=%h sof=%b eol=%b, required no word",
                         out_data, out_sof, out_eol);
            end else begin
                e = exp_q.pop_front();
                if (out_data !== e.data || out_sof !== e.sof || out_eol !== e.eol) begin
                    n_fail++;
                    $display("FAIL word: got data=%h sof=%b eol=%b, required data=%h sof=%b eol=%b",
                             out_data, out_sof, out_eol, e.data, e.sof, e.eol);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    task automatic vsync_pulse();
        cam_vsync = 1'b1;
        idle(2);
        cam_vsync = 1'b0;
        idle(3);
    endtask

    // Drives n pixels first, first+1, ... and optionally records the words they should produce.
    task automatic send_line(input int n, input logic [15:0] first, input bit expect_words,
                             input bit sof);
        word_t       w;
        logic [15:0] lo, hi;
        if (expect_words) begin
            for (int k = 0; k < n; k += 2) begin
                lo = first + 16'(k);
                hi = first + 16'(k + 1);
                w.data = (k + 1 < n) ? {hi, lo} : {16'h0000, lo};
                w.sof  = sof && (k == 0);
                w.eol  = (k + 2 >= n);
                exp_q.push_back(w);
            end
        end
        cam_hsync = 1'b1;
        cycle();
        cam_hsync = 1'b0;
        for (int i = 0; i < n; i++) begin
            cam_valid = 1'b1;
            cam_data  = first + 16'(i);
            cycle();
        end
        cam_valid = 1'b0;
        cam_data  = 16'h0000;
        idle(4);
    endtask

    task automatic wait_drain(input string name);
        int t = 0;
        while ((exp_q.size() != 0 || out_valid) && t < 200) begin
            cycle();
            t++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: %0d words still expected, required 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        idle(3);
        n_checks++;
        if ({out_valid, out_sof, out_eol, frame_done, err_ovf, err_line, err_frame} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b, required 0000000",
                     {out_valid, out_sof, out_eol, frame_done, err_ovf, err_line, err_frame});
        end
        n_checks++;
        if (out_data !== 32'd0 || frame_count !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_data: got data=%h count=%0d, required 0 and 0", out_data, frame_count);
        end
        resetn = 1'b1;
        idle(2);
        n_checks++;
        if (dut.state !== S_DISABLED) begin
            n_fail++;
            $display("FAIL reset_state: got %0d, required %0d", dut.state, S_DISABLED);
        end
    endtask

    task automatic test_nominal();
        int start;
        cap_en = 1'b1;
        idle(2);
        start = done_total;
        vsync_pulse();
        send_line(4, 16'h0001, 1'b1, 1'b1);
        send_line(4, 16'h0005, 1'b1, 1'b0);
        wait_drain("nominal");
        n_checks++;
        if (done_total - start != 1) begin
            n_fail++;
            $display("FAIL nominal_done: got %0d pulses, required 1", done_total - start);
        end
        n_checks++;
        if (frame_count !== 16'd1 || {err_ovf, err_line, err_frame} !== 3'b000) begin
            n_fail++;
            $display("FAIL nominal_status: got count=%0d err=%b, required 1 and 000",
                     frame_count, {err_ovf, err_line, err_frame});
        end
    endtask

    task automatic test_short_line();
        vsync_pulse();
        send_line(3, 16'h00A1, 1'b1, 1'b1);
        send_line(4, 16'h0011, 1'b1, 1'b0);
        wait_drain("short");
        n_checks++;
        if (err_line !== 1'b1 || frame_count !== 16'd2) begin
            n_fail++;
            $display("FAIL short_err_line: got err_line=%b count=%0d, required 1 and 2",
                     err_line, frame_count);
        end
        err_clr = 1'b1;
        cycle();
        err_clr = 1'b0;
        cycle();
        n_checks++;
        if (err_line !== 1'b0) begin
            n_fail++;
            $display("FAIL short_err_clr: got err_line=%b, required 0", err_line);
        end
    endtask

    task automatic test_backpressure();
        int start;
        start = done_total;
        out_ready = 1'b0;
        vsync_pulse();
        send_line(4, 16'h0021, 1'b1, 1'b1);
        send_line(4, 16'h0025, 1'b0, 1'b0);
        n_checks++;
        if (err_ovf !== 1'b1 || dut.state !== S_DROP) begin
            n_fail++;
            $display("FAIL bp_overflow: got err_ovf=%b state=%0d, required 1 and %0d",
                     err_ovf, dut.state, S_DROP);
        end
        n_checks++;
        if (done_total != start || frame_count !== 16'd2) begin
            n_fail++;
            $display("FAIL bp_no_frame: got pulses=%0d count=%0d, required 0 and 2",
                     done_total - start, frame_count);
        end
        out_ready = 1'b1;
        wait_drain("bp_flush");
        vsync_pulse();
        send_line(4, 16'h0031, 1'b1, 1'b1);
        send_line(4, 16'h0035, 1'b1, 1'b0);
        wait_drain("bp_recover");
        n_checks++;
        if (frame_count !== 16'd3) begin
            n_fail++;
            $display("FAIL bp_count: got %0d, required 3", frame_count);
        end
    endtask

    task automatic test_early_vsync();
        int start;
        err_clr = 1'b1;
        cycle();
        err_clr = 1'b0;
        cycle();
        n_checks++;
        if ({err_ovf, err_line, err_frame} !== 3'b000) begin
            n_fail++;
            $display("FAIL early_clear: got %b, required 000", {err_ovf, err_line, err_frame});
        end
        start = done_total;
        vsync_pulse();
        send_line(4, 16'h0041, 1'b1, 1'b1);
        vsync_pulse();
        n_checks++;
        if (err_frame !== 1'b1 || done_total != start || frame_count !== 16'd3) begin
            n_fail++;
            $display("FAIL early_abort: got err_frame=%b pulses=%0d count=%0d, required 1 0 3",
                     err_frame, done_total - start, frame_count);
        end
        send_line(4, 16'h0051, 1'b1, 1'b1);
        send_line(4, 16'h0055, 1'b1, 1'b0);
        wait_drain("early");
        n_checks++;
        if (frame_count !== 16'd4 || done_total - start != 1) begin
            n_fail++;
            $display("FAIL early_next: got count=%0d pulses=%0d, required 4 and 1",
                     frame_count, done_total - start);
        end
    endtask

    task automatic test_cap_en_drop();
        int start;
        start = done_total;
        vsync_pulse();
        send_line(4, 16'h0061, 1'b1, 1'b1);
        cap_en = 1'b0;
        send_line(4, 16'h0065, 1'b1, 1'b0);
        wait_drain("capen");
        n_checks++;
        if (done_total - start != 1 || frame_count !== 16'd5 || dut.state !== S_DISABLED) begin
            n_fail++;
            $display("FAIL capen_finish: got pulses=%0d count=%0d state=%0d, required 1 5 %0d",
                     done_total - start, frame_count, dut.state, S_DISABLED);
        end
        seen_valid = 1'b0;
        vsync_pulse();
        send_line(4, 16'h0071, 1'b0, 1'b0);
        idle(4);
        n_checks++;
        if (seen_valid !== 1'b0 || frame_count !== 16'd5) begin
            n_fail++;
            $display("FAIL capen_ignored: got out_valid_seen=%b count=%0d, required 0 and 5",
                     seen_valid, frame_count);
        end
    endtask

    task automatic test_reset_mid_line();
        cap_en    = 1'b1;
        out_ready = 1'b0;
        idle(2);
        vsync_pulse();
        for (int i = 0; i < 5; i++) begin
            cam_valid = 1'b1;
            cam_data  = 16'h0081 + 16'(i);
            cycle();
        end
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_pre_valid: got %b, required 1", out_valid);
        end
        resetn   = 1'b0;
        cam_data = 16'h0086;
        cycle();
        n_checks++;
        if ({out_valid, out_sof, out_eol, frame_done, err_ovf, err_line, err_frame} !== 7'b0
            || out_data !== 32'd0 || frame_count !== 16'd0) begin
            n_fail++;
            $display("FAIL rst_mid: got flags=%b data=%h count=%0d, required 0000000 0 0",
                     {out_valid, out_sof, out_eol, frame_done, err_ovf, err_line, err_frame},
                     out_data, frame_count);
        end
        resetn    = 1'b1;
        cam_valid = 1'b0;
        cam_data  = 16'h0000;
        out_ready = 1'b1;
        exp_q.delete();
        seen_valid = 1'b0;
        idle(3);
        send_line(4, 16'h0091, 1'b0, 1'b0);
        n_checks++;
        if (seen_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_no_vsync: got out_valid_seen=%b, required 0", seen_valid);
        end
        vsync_pulse();
        send_line(4, 16'h00B1, 1'b1, 1'b1);
        send_line(4, 16'h00B5, 1'b1, 1'b0);
        wait_drain("rst_resume");
        n_checks++;
        if (frame_count !== 16'd1) begin
            n_fail++;
            $display("FAIL rst_count: got %0d, required 1", frame_count);
        end
    endtask

    initial begin
        resetn    = 1'b0;
        cam_vsync = 1'b0;
        cam_hsync = 1'b0;
        cam_valid = 1'b0;
        cam_data  = 16'h0000;
        cap_en    = 1'b0;
        err_clr   = 1'b0;
        out_ready = 1'b1;

        test_reset();
        test_nominal();
        test_short_line();
        test_backpressure();
        test_early_vsync();
        test_cap_en_drop();
        test_reset_mid_line();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
